// File: rtl/soc_addr_rule_decoder_if.sv
// Bus bundle for soc_addr_rule_decoder.
//   cfg_*  : single-cycle config strobe (write / read) with read data and error
//            returned one cycle later.
//   req_*  : decode request handshake (valid/ready, address).
//   resp_* : decode response handshake (valid/ready, matched index, hit flag).
//   miss_cnt_o : saturating count of accepted requests that missed.
// The master modport is the requester side; the slave modport is the decoder.
interface soc_addr_rule_decoder_if #(
  parameter int unsigned NumRules  = 11,
  parameter int unsigned AddrWidth = 64
);
  localparam int unsigned IdxW = (NumRules > 1) ? $clog2(NumRules) : 1;

  logic                 cfg_valid_i;
  logic                 cfg_we_i;
  logic [IdxW-1:0]      cfg_idx_i;
  logic [1:0]           cfg_field_i;
  logic [AddrWidth-1:0] cfg_wdata_i;
  logic                 cfg_rvalid_o;
  logic [AddrWidth-1:0] cfg_rdata_o;
  logic                 cfg_err_o;

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;

  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [IdxW-1:0]      resp_idx_o;
  logic                 resp_hit_o;

  logic [31:0]          miss_cnt_o;

  modport master (
    output cfg_valid_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
    input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    output req_valid_i, req_addr_i,
    input  req_ready_o,
    input  resp_valid_o, resp_idx_o, resp_hit_o,
    output resp_ready_i,
    input  miss_cnt_o
  );

  modport slave (
    input  cfg_valid_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
    output cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    input  req_valid_i, req_addr_i,
    output req_ready_o,
    output resp_valid_o, resp_idx_o, resp_hit_o,
    input  resp_ready_i,
    output miss_cnt_o
  );
endinterface

// File: rtl/soc_addr_rule_decoder.sv
// Programmable address-rule decoder.
//   clk_i  : clock, all state on rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : soc_addr_rule_decoder_if.slave (config port, decode req/resp,
//            miss counter)
// Each rule is {base, len, enable}. An address matches rule r when enabled,
// addr >= base and addr - base < len (AddrWidth arithmetic, so a rule running
// past the top of the address space never wraps to 0). Lowest index wins.
// A sticky lock bit freezes the rule table until reset; reads stay allowed.
module soc_addr_rule_decoder #(
  parameter int unsigned NumRules  = 11,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NumRules-1:0][AddrWidth-1:0] RuleBaseRst = {
    64'h0000_0000, 64'h1900_0000, 64'h0001_0000, 64'h0200_0000,
    64'h0C00_0000, 64'h1000_0000, 64'h1800_0000, 64'h2000_0000,
    64'h3000_0000, 64'h4000_0000, 64'h8000_0000},
  parameter logic [NumRules-1:0][AddrWidth-1:0] RuleLenRst = {
    64'h0000_1000, 64'h0000_1000, 64'h0001_0000, 64'h000C_0000,
    64'h03FF_FFFF, 64'h0000_1000, 64'h0000_1000, 64'h0080_0000,
    64'h0001_0000, 64'h0000_1000, 64'h4000_0000},
  parameter int unsigned DefaultIdx = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  soc_addr_rule_decoder_if.slave  bus
);
  localparam int unsigned IdxW = (NumRules > 1) ? $clog2(NumRules) : 1;

  logic [NumRules-1:0][AddrWidth-1:0] base_q, base_d, len_q, len_d;
  logic [NumRules-1:0]                en_q, en_d;
  logic                               lock_q, lock_d;
  logic                               rvalid_q, rvalid_d;
  logic [AddrWidth-1:0]               rdata_q, rdata_d;
  logic                               err_q, err_d;
  logic                               resp_valid_q, resp_valid_d;
  logic [IdxW-1:0]                    resp_idx_q, resp_idx_d;
  logic                               resp_hit_q, resp_hit_d;
  logic [31:0]                        miss_cnt_q, miss_cnt_d;

  logic [NumRules-1:0] match;
  logic                dec_hit;
  logic [IdxW-1:0]     dec_idx;
  logic                accept;
  logic                cfg_in_range;

  // Decode against the registered table, so a same-cycle config write is
  // only seen by requests from the next cycle onward.
  always_comb begin
    match = '0;
    for (int r = 0; r < NumRules; r++) begin
      match[r] = en_q[r] && (bus.req_addr_i >= base_q[r]) &&
                 ((bus.req_addr_i - base_q[r]) < len_q[r]);
    end
    dec_hit = |match;
    dec_idx = IdxW'(DefaultIdx);
    // Walk high to low so the lowest matching index is the last written.
    for (int r = NumRules - 1; r >= 0; r--) begin
      if (match[r]) dec_idx = IdxW'(r);
    end
  end

  assign cfg_in_range = 32'(bus.cfg_idx_i) < NumRules;

  always_comb begin
    base_d   = base_q;
    len_d    = len_q;
    en_d     = en_q;
    lock_d   = lock_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    if (bus.cfg_valid_i) begin
      if (bus.cfg_we_i) begin
        // Field 3 ignores the index, so only the lock gates it.
        if (lock_q || (bus.cfg_field_i != 2'd3 && !cfg_in_range)) begin
          err_d = 1'b1;
        end else begin
          case (bus.cfg_field_i)
            2'd0:    base_d[bus.cfg_idx_i] = bus.cfg_wdata_i;
            2'd1:    len_d[bus.cfg_idx_i]  = bus.cfg_wdata_i;
            2'd2:    en_d[bus.cfg_idx_i]   = bus.cfg_wdata_i[0];
            default: if (bus.cfg_wdata_i[0]) lock_d = 1'b1;
          endcase
        end
      end else begin
        rvalid_d = 1'b1;
        rdata_d  = '0;
        if (bus.cfg_field_i == 2'd3) begin
          rdata_d[0] = lock_q;
        end else if (!cfg_in_range) begin
          err_d = 1'b1;
        end else begin
          case (bus.cfg_field_i)
            2'd0:    rdata_d    = base_q[bus.cfg_idx_i];
            2'd1:    rdata_d    = len_q[bus.cfg_idx_i];
            default: rdata_d[0] = en_q[bus.cfg_idx_i];
          endcase
        end
      end
    end
  end

  assign bus.req_ready_o = !resp_valid_q || bus.resp_ready_i;
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_idx_d   = resp_idx_q;
    resp_hit_d   = resp_hit_q;
    miss_cnt_d   = miss_cnt_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_idx_d   = dec_idx;
      resp_hit_d   = dec_hit;
      if (!dec_hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
    end else if (bus.resp_ready_i) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q       <= RuleBaseRst;
      len_q        <= RuleLenRst;
      en_q         <= '1;
      lock_q       <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_hit_q   <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      base_q       <= base_d;
      len_q        <= len_d;
      en_q         <= en_d;
      lock_q       <= lock_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_idx_q   <= resp_idx_d;
      resp_hit_q   <= resp_hit_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.cfg_rvalid_o = rvalid_q;
  assign bus.cfg_rdata_o  = rdata_q;
  assign bus.cfg_err_o    = err_q;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_idx_o   = resp_idx_q;
  assign bus.resp_hit_o   = resp_hit_q;
  assign bus.miss_cnt_o   = miss_cnt_q;
endmodule

// File: doc/soc_addr_rule_decoder.md
SOC_ADDR_RULE_DECODER -- requirements
Module: soc_addr_rule_decoder

Interface
REQ-001 SHALL have parameter NumRules, default 11, number of address rules (1..32).
REQ-002 SHALL have parameter AddrWidth, default 64, address and length width.
REQ-003 SHALL have parameter RuleBaseRst, default the SoC map bases (rule 0 0x8000_0000, 1 0x4000_0000, 2 0x3000_0000, 3 0x2000_0000, 4 0x1800_0000, 5 0x1000_0000, 6 0x0C00_0000, 7 0x0200_0000, 8 0x0001_0000, 9 0x1900_0000, 10 0x0000_0000), per-rule reset base.
REQ-004 SHALL have parameter RuleLenRst, default the matching SoC lengths (0x4000_0000, 0x1000, 0x10000, 0x80_0000, 0x1000, 0x1000, 0x3FF_FFFF, 0xC_0000, 0x1_0000, 0x1000, 0x1000), per-rule reset length.
REQ-005 SHALL have parameter DefaultIdx, default 0, index reported on a miss; IdxW = max(1, clog2(NumRules)) is derived.
REQ-006 clk_i  input  1  clock, all state on rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 cfg_valid_i  input  1  config access strobe (single cycle, always accepted).
REQ-009 cfg_we_i  input  1  1 = write, 0 = read.
REQ-010 cfg_idx_i  input  IdxW  rule index.
REQ-011 cfg_field_i  input  2  0 base, 1 length, 2 enable (bit 0), 3 lock (bit 0, index ignored).
REQ-012 cfg_wdata_i  input  AddrWidth  write data.
REQ-013 cfg_rvalid_o  output  1  read data valid, one cycle after a read strobe.
REQ-014 cfg_rdata_o  output  AddrWidth  read data.
REQ-015 cfg_err_o  output  1  pulses with cfg_rvalid_o timing on a rejected access.
REQ-016 req_valid_i / req_ready_o / req_addr_i  in/out/in  1/1/AddrWidth  decode request handshake.
REQ-017 resp_valid_o / resp_ready_i  out/in  1/1  decode response handshake.
REQ-018 resp_idx_o  output  IdxW  matched rule; resp_hit_o  output  1  match found.
REQ-019 miss_cnt_o  output  32  count of accepted requests that missed.

Function
REQ-020 Rule r SHALL match addr when enable[r]=1, addr >= base[r], and (addr - base[r]) < len[r], computed in AddrWidth bits; len 0 never matches; no overflow at base+len wrap.
REQ-021 On multiple matches the lowest index SHALL win.
REQ-022 On no match resp_hit_o SHALL be 0 and resp_idx_o SHALL be DefaultIdx.
REQ-023 Request accepted when req_valid_i & req_ready_o; result registered, resp_valid_o high the next cycle (latency 1).
REQ-024 req_ready_o SHALL equal !resp_valid_o | resp_ready_i; full throughput of one decode per cycle when resp_ready_i held 1.
REQ-025 While resp_valid_o & !resp_ready_i, resp_idx_o/resp_hit_o SHALL hold stable.
REQ-026 Decode in the same cycle as a config write SHALL use pre-write rule values; write visible from the following cycle.
REQ-027 Config write SHALL update the selected field when unlocked and cfg_idx_i < NumRules.
REQ-028 Write to field 3 with bit 0 = 1 SHALL set lock; lock is sticky until reset; writing 0 has no effect.
REQ-029 Any write while locked, or any access with cfg_idx_i >= NumRules (fields 0-2), SHALL be dropped and pulse cfg_err_o one cycle later.
REQ-030 Read SHALL return field value zero-extended (enable/lock in bit 0) one cycle later with cfg_rvalid_o=1; out-of-range reads return 0.
REQ-031 Reads SHALL be permitted while locked.
REQ-032 miss_cnt_o SHALL increment by 1 per accepted missing request and saturate at 0xFFFF_FFFF.

Reset
REQ-033 On rst_ni low, immediately: base/len = RuleBaseRst/RuleLenRst, all enables 1, lock 0, resp_valid_o 0, resp_hit_o 0, resp_idx_o 0, cfg_rvalid_o 0, cfg_err_o 0, cfg_rdata_o 0, miss_cnt_o 0.
REQ-034 Reset asserted mid-transaction SHALL discard a pending response and in-flight read without completing them.

Verification
REQ-035 After reset, addr 0x8000_1000 -> resp_hit_o 1, resp_idx_o 0 next cycle; addr 0x1000_0FFF -> idx 5; addr 0x1000_1000 -> hit 0, idx 0, miss_cnt_o 1.
REQ-036 Write rule 9 base 0x1000_0000 (overlaps rule 5), decode 0x1000_0004 -> idx 5 (lowest wins); disable rule 5 -> idx 9.
REQ-037 resp_ready_i held 0 for 3 cycles with req_valid_i high -> req_ready_o 0, response stable, then one transfer per cycle on release, no loss or duplication.
REQ-038 Write lock, then write rule 0 length 0 -> cfg_err_o pulse, read back 0x4000_0000; read cfg_idx_i 15 -> rdata 0, cfg_err_o pulse.
REQ-039 Rule base 0xFFFF_FFFF_FFFF_F000 length 0x2000 -> addr 0xFFFF_FFFF_FFFF_FFFF hits, addr 0x0 misses (no wrap).
REQ-040 Force miss_cnt to 0xFFFF_FFFE, issue 3 misses -> miss_cnt_o 0xFFFF_FFFF; assert rst_ni with resp_valid_o high -> resp_valid_o 0 immediately.
